vector_load_sequencer: RTL

Front-end controller for the 4-lane vector pipeline (IF/ID/EXE/MEM).
- Accepts a 32-bit word stream and packs it into 4-word beats.
- Writes 8 kernel coefficients into the multiplier register file, then 8 pixels per tile into the pixel register file.
- For each tile, releases the pipeline from reset for a fixed run window, then re-arms it.
- Sits between the external stream source and the pipeline's register-file write ports and reset.

---
 rtl/vector_ctrl_pkg.sv | 21 ++
 rtl/beat_packer.sv | 40 ++++
 rtl/vector_load_sequencer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/vector_ctrl_pkg.sv
// Shared types for the vector pipeline front-end: controller states, beat
// geometry and the packed 4-word beat carried to the register-file write ports.
package vector_ctrl_pkg;

   localparam int WORDS_PER_BEAT = 4;
   localparam int HALVES         = 2;
   localparam int BEAT_DW        = 32;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOAD_MUL = 3'd1,
      ST_LOAD_PXL = 3'd2,
      ST_WRITE    = 3'd3,
      ST_RUN      = 3'd4,
      ST_FIN      = 3'd5
   } ctrl_state_t;

   // Lane 0 of the array is lane 1 on the register-file write ports.
   typedef logic [WORDS_PER_BEAT-1:0][BEAT_DW-1:0] beat_t;

endpackage

// File: rtl/beat_packer.sv
// Gathers accepted stream words into a 4-word beat. beat shows the gathered
// words merged with the word accepted this cycle, so it is complete when beat_full pulses.
module beat_packer
   import vector_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               push,
   input  logic [BEAT_DW-1:0] data,
   output beat_t              beat,
   output logic               beat_full
);

   localparam int WC_W = $clog2(WORDS_PER_BEAT);

   logic [WC_W-1:0] word_cnt;
   beat_t           gather;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_cnt <= '0;
         gather   <= '0;
      end else if (clear) begin
         word_cnt <= '0;
         gather   <= '0;
      end else if (push) begin
         gather[word_cnt] <= data;
         word_cnt         <= word_cnt + WC_W'(1);
      end
   end

   always_comb begin
      beat = gather;
      if (push) beat[word_cnt] = data;
   end

   assign beat_full = push && (word_cnt == WC_W'(WORDS_PER_BEAT - 1));

endmodule

// File: rtl/vector_load_sequencer.sv
// Front-end controller: loads kernel and pixel beats into the vector pipeline
// register files and runs the pipeline one tile at a time. Optional build macro
// KERNEL_RELOAD_EN reloads the 8 coefficients ahead of every tile.
module vector_load_sequencer
   import vector_ctrl_pkg::*;
#(
   parameter int DW         = BEAT_DW,
   parameter int RUN_CYCLES = 20,
   parameter int TILE_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [TILE_W-1:0] tile_count,
   input  logic              in_valid,
   input  logic [DW-1:0]     in_data,
   output logic              in_ready,
   output logic              cpu_rst,
   output logic              we_mul,
   output logic              wr_mul_pos,
   output logic              we_pxl,
   output logic              wr_pos_pxl,
   output logic [DW-1:0]     wdm1,
   output logic [DW-1:0]     wdm2,
   output logic [DW-1:0]     wdm3,
   output logic [DW-1:0]     wdm4,
   output logic [DW-1:0]     wdp1,
   output logic [DW-1:0]     wdp2,
   output logic [DW-1:0]     wdp3,
   output logic [DW-1:0]     wdp4,
   output logic              busy,
   output logic              done,
   output logic [TILE_W-1:0] tile_idx,
   output ctrl_state_t       state_dbg
);

   // Stream handshake: a word transfers on a rising edge where in_valid && in_ready;
   // in_ready depends only on state, never on in_valid.

`ifdef KERNEL_RELOAD_EN
   localparam bit RELOAD = 1'b1;
`else
   localparam bit RELOAD = 1'b0;
`endif

   localparam int RC_W = $clog2(RUN_CYCLES + 1);
   localparam int HW   = $clog2(HALVES);
   localparam logic [HW-1:0] HALF_LAST = HW'(HALVES - 1);

   ctrl_state_t       state, state_nxt;
   logic [HW-1:0]     half;
   logic              pxl_phase;
   logic [TILE_W-1:0] tile_total;
   logic [RC_W-1:0]   run_cnt;
   beat_t             beat, wdm_q, wdp_q;
   logic              beat_full, push, start_acc, run_done, last_tile;
   logic              load_mul_full, load_pxl_full;

   assign in_ready      = (state == ST_LOAD_MUL) || (state == ST_LOAD_PXL);
   assign push          = in_valid && in_ready;
   assign start_acc     = (state == ST_IDLE) && start;
   assign run_done      = (run_cnt == '0);
   assign last_tile     = ((tile_idx + TILE_W'(1)) == tile_total);
   assign load_mul_full = (state == ST_LOAD_MUL) && beat_full;
   assign load_pxl_full = (state == ST_LOAD_PXL) && beat_full;
   assign state_dbg     = state;

   beat_packer u_packer (
      .clk       (clk),
      .rst       (rst),
      .clear     (start_acc),
      .push      (push),
      .data      (in_data),
      .beat      (beat),
      .beat_full (beat_full)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (start) state_nxt = (tile_count == '0) ? ST_FIN : ST_LOAD_MUL;
         end
         ST_LOAD_MUL, ST_LOAD_PXL: begin
            if (beat_full) state_nxt = ST_WRITE;
         end
         ST_WRITE: begin
            if (half != HALF_LAST) state_nxt = pxl_phase ? ST_LOAD_PXL : ST_LOAD_MUL;
            else if (!pxl_phase)   state_nxt = ST_LOAD_PXL;
            else                   state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (run_done) begin
               if (last_tile)   state_nxt = ST_FIN;
               else if (RELOAD) state_nxt = ST_LOAD_MUL;
               else             state_nxt = ST_LOAD_PXL;
            end
         end
         ST_FIN:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Strobes and cpu_rst are registered off state_nxt so they line up with the state they describe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy       <= 1'b0;
         cpu_rst    <= 1'b1;
         we_mul     <= 1'b0;
         we_pxl     <= 1'b0;
         wr_mul_pos <= 1'b0;
         wr_pos_pxl <= 1'b0;
         wdm_q      <= '0;
         wdp_q      <= '0;
         half       <= '0;
         pxl_phase  <= 1'b0;
         tile_total <= '0;
         tile_idx   <= '0;
         run_cnt    <= '0;
         done       <= 1'b0;
      end else begin
         busy    <= (state_nxt != ST_IDLE);
         cpu_rst <= (state_nxt != ST_RUN);
         we_mul  <= load_mul_full;
         we_pxl  <= load_pxl_full;
         if (load_mul_full) begin
            wdm_q      <= beat;
            wr_mul_pos <= half[0];
         end
         if (load_pxl_full) begin
            wdp_q      <= beat;
            wr_pos_pxl <= half[0];
         end
         case (state)
            ST_IDLE: begin
               if (start_acc) begin
                  tile_total <= tile_count;
                  tile_idx   <= '0;
                  done       <= 1'b0;
                  half       <= '0;
                  pxl_phase  <= 1'b0;
               end
            end
            ST_WRITE: begin
               half <= half + HW'(1);
               if (half == HALF_LAST && !pxl_phase) pxl_phase <= 1'b1;
               if (state_nxt == ST_RUN) run_cnt <= RC_W'(RUN_CYCLES - 1);
            end
            ST_RUN: begin
               if (run_done) begin
                  tile_idx  <= tile_idx + TILE_W'(1);
                  half      <= '0;
                  pxl_phase <= !RELOAD;
               end else begin
                  run_cnt <= run_cnt - RC_W'(1);
               end
            end
            ST_FIN:  done <= 1'b1;
            default: ;
         endcase
      end
   end

   assign wdm1 = wdm_q[0];
   assign wdm2 = wdm_q[1];
   assign wdm3 = wdm_q[2];
   assign wdm4 = wdm_q[3];
   assign wdp1 = wdp_q[0];
   assign wdp2 = wdp_q[1];
   assign wdp3 = wdp_q[2];
   assign wdp4 = wdp_q[3];

endmodule
